// File: rtl/bmp_pkg.sv
// Shared definitions for the BMP/font placement command front-end:
// register offsets, status bit layout, CTRL bit meanings and issue FSM states.
package bmp_pkg;

   // Word offsets inside the 4-word register window
   localparam logic [1:0] OFS_X    = 2'd0;
   localparam logic [1:0] OFS_Y    = 2'd1;
   localparam logic [1:0] OFS_CMD  = 2'd2;
   localparam logic [1:0] OFS_CTRL = 2'd3;

   // Status word layout: {8'b0, overflow, full, empty, count[4:0]}
   localparam int STAT_OVF   = 7;
   localparam int STAT_FULL  = 6;
   localparam int STAT_EMPTY = 5;
   localparam int STAT_CNT_W = 5;

   // CTRL write bits
   localparam int CTRL_CLR_OVF = 0;
   localparam int CTRL_FLUSH   = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HOLD  = 2'd2
   } bmp_state_e;

   function automatic logic [15:0] pack_status(input logic ovf, input logic full,
                                               input logic empty,
                                               input logic [STAT_CNT_W-1:0] cnt);
      return {8'b0, ovf, full, empty, cnt};
   endfunction

endpackage

// File: rtl/bmp_cmd_queue_if.sv
// CPU-bus and placer-side signal bundle of the command queue.
// slave = the queue itself, master = the bus decode / placer side.
interface bmp_cmd_queue_if #(
   parameter int XW   = 10,
   parameter int YW   = 9,
   parameter int IDXW = 6
);
   logic            bmp_sel;
   logic            bmp_rd;
   logic [15:0]     addr;
   logic [15:0]     databus;
   logic [15:0]     rdata;
   logic            placer_ready;
   logic            add_img;
   logic            add_fnt;
   logic [IDXW-1:0] image_indx;
   logic [XW-1:0]   xloc;
   logic [YW-1:0]   yloc;

   modport master (
      output bmp_sel, bmp_rd, addr, databus, placer_ready,
      input  rdata, add_img, add_fnt, image_indx, xloc, yloc
   );

   modport slave (
      input  bmp_sel, bmp_rd, addr, databus, placer_ready,
      output rdata, add_img, add_fnt, image_indx, xloc, yloc
   );
endinterface

// File: rtl/bmp_cmd_fifo.sv
// Synchronous DEPTH-entry FIFO with push/pop/flush. A push while full is
// accepted only if a pop frees a slot in the same cycle; flush wins over push.
module bmp_cmd_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   input  logic [W-1:0]               wdata_i,
   output logic [W-1:0]               rdata_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic                       accept_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          pop_ok;

   assign full_o   = (count_q == CW'(DEPTH));
   assign empty_o  = (count_q == '0);
   assign count_o  = count_q;
   assign rdata_o  = mem_q[rd_ptr_q];
   assign pop_ok   = pop_i & ~empty_o;
   assign accept_o = push_i & ~flush_i & (~full_o | pop_ok);

   // Pointer/count next state; flush returns everything to the empty state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (accept_o) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok)   rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(accept_o) - CW'(pop_ok);
      end
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents need no reset since occupancy gates reads
   always_ff @(posedge clk) begin
      if (accept_o) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/bmp_cmd_queue.sv
// Memory-mapped command front-end for the BMP/font placer: XLOC/YLOC/CMD
// registers feeding a command FIFO, a CTRL/STATUS register, and a three-state
// issue FSM with a ready handshake to the placer.
// Optional feature: define BMP_AUTOINC_EN to advance XLOC (and wrap into
// YLOC) after every accepted CMD push, for text-cursor style glyph runs.
module bmp_cmd_queue
   import bmp_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR = 16'hC008,
   parameter int          DEPTH     = 8,
   parameter int          XW        = 10,
   parameter int          YW        = 9,
   parameter int          IDXW      = 6,
   parameter int          XSTEP     = 8,
   parameter int          YSTEP     = 8,
   parameter int          XMAX      = 640
)(
   input  logic             clk,
   input  logic             rst_n,
   bmp_cmd_queue_if.slave   bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int FW = XW + YW + IDXW + 1;

   // Bus decode
   logic [15:0] offset;
   logic        in_win;
   logic        wr_x, wr_y, wr_cmd, wr_ctrl, rd_hit;
   logic        flush, clr_ovf;

   assign offset  = bus.addr - BASE_ADDR;
   assign in_win  = (offset < 16'd4);
   assign wr_x    = bus.bmp_sel & in_win & (offset[1:0] == OFS_X);
   assign wr_y    = bus.bmp_sel & in_win & (offset[1:0] == OFS_Y);
   assign wr_cmd  = bus.bmp_sel & in_win & (offset[1:0] == OFS_CMD);
   assign wr_ctrl = bus.bmp_sel & in_win & (offset[1:0] == OFS_CTRL);
   assign rd_hit  = bus.bmp_rd & in_win;
   assign flush   = wr_ctrl & bus.databus[CTRL_FLUSH];
   assign clr_ovf = wr_ctrl & bus.databus[CTRL_CLR_OVF];

   logic unused_databus;
   assign unused_databus = ^bus.databus;

   // Register-file state
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          overflow_q, overflow_d;
   logic [15:0]   rdata_q, rdata_d;

   // FIFO
   logic [FW-1:0] fifo_wdata, fifo_rdata;
   logic [CW-1:0] fifo_count;
   logic          fifo_full, fifo_empty, fifo_accept;
   logic          pop, dropped;
   logic [15:0]   status;

   // Issue FSM and output registers
   bmp_state_e      state_q;
   logic            kind_q;
   logic            add_img_q, add_fnt_q;
   logic [XW-1:0]   xloc_q;
   logic [YW-1:0]   yloc_q;
   logic [IDXW-1:0] idx_q;

   logic [XW-1:0]   head_x;
   logic [YW-1:0]   head_y;
   logic [IDXW-1:0] head_idx;
   logic            head_img;

   assign fifo_wdata = {x_q, y_q, bus.databus[IDXW:1], bus.databus[0]};
   assign {head_x, head_y, head_idx, head_img} = fifo_rdata;
   assign pop     = (state_q == ST_IDLE) & ~fifo_empty & bus.placer_ready;
   assign dropped = wr_cmd & ~flush & ~fifo_accept;
   assign status  = pack_status(overflow_q, fifo_full, fifo_empty, STAT_CNT_W'(fifo_count));

   bmp_cmd_fifo #(
      .W     (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_i   (wr_cmd),
      .pop_i    (pop),
      .flush_i  (flush),
      .wdata_i  (fifo_wdata),
      .rdata_o  (fifo_rdata),
      .count_o  (fifo_count),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty),
      .accept_o (fifo_accept)
   );

`ifdef BMP_AUTOINC_EN
   localparam logic [XW:0]   XSTEP_W = (XW+1)'(XSTEP);
   localparam logic [XW:0]   XMAX_W  = (XW+1)'(XMAX);
   localparam logic [YW-1:0] YSTEP_W = YW'(YSTEP);
   logic [XW:0] x_sum;
`endif

   // Next state of cursor registers, sticky overflow and read data
   always_comb begin
      x_d        = x_q;
      y_d        = y_q;
      overflow_d = overflow_q;
      rdata_d    = rdata_q;
`ifdef BMP_AUTOINC_EN
      x_sum      = '0;
`endif
      if (wr_x) x_d = bus.databus[XW-1:0];
      if (wr_y) y_d = bus.databus[YW-1:0];
`ifdef BMP_AUTOINC_EN
      // Only a command that actually lands in the FIFO moves the cursor
      if (fifo_accept) begin
         x_sum = {1'b0, x_q} + XSTEP_W;
         if (x_sum >= XMAX_W) begin
            x_d = '0;
            y_d = y_q + YSTEP_W;
         end else begin
            x_d = x_sum[XW-1:0];
         end
      end
`endif
      if (clr_ovf) overflow_d = 1'b0;
      if (dropped) overflow_d = 1'b1;
      // Status sampled before this cycle's push/pop takes effect
      if (rd_hit) rdata_d = (offset[1:0] == OFS_CTRL) ? status : 16'h0000;
   end

   // Cursor, overflow and read-data registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_q        <= '0;
         y_q        <= '0;
         overflow_q <= 1'b0;
         rdata_q    <= '0;
      end else begin
         x_q        <= x_d;
         y_q        <= y_d;
         overflow_q <= overflow_d;
         rdata_q    <= rdata_d;
      end
   end

   // Issue FSM: IDLE pops the head, ISSUE fires the pulse, HOLD ignores ready
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         kind_q    <= 1'b0;
         add_img_q <= 1'b0;
         add_fnt_q <= 1'b0;
         xloc_q    <= '0;
         yloc_q    <= '0;
         idx_q     <= '0;
      end else begin
         add_img_q <= 1'b0;
         add_fnt_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  xloc_q  <= head_x;
                  yloc_q  <= head_y;
                  idx_q   <= head_idx;
                  kind_q  <= head_img;
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               add_img_q <= kind_q;
               add_fnt_q <= ~kind_q;
               state_q   <= ST_HOLD;
            end
            ST_HOLD: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.rdata      = rdata_q;
   assign bus.add_img    = add_img_q;
   assign bus.add_fnt    = add_fnt_q;
   assign bus.image_indx = idx_q;
   assign bus.xloc       = xloc_q;
   assign bus.yloc       = yloc_q;

endmodule

// File: tb/tb_bmp_cmd_queue.sv
// Scoreboard bench for bmp_cmd_queue: every CMD push that should reach the
// placer queues an expected {kind, index, x, y}; each observed add pulse pops
// and compares. Cursor expectations follow BMP_AUTOINC_EN when it is defined.
module tb_bmp_cmd_queue;
   localparam int DEPTH = 8;
   localparam logic [15:0] A_X    = 16'hC008;
   localparam logic [15:0] A_Y    = 16'hC009;
   localparam logic [15:0] A_CMD  = 16'hC00A;
   localparam logic [15:0] A_CTRL = 16'hC00B;

   typedef struct packed {
      logic       img;
      logic [5:0] idx;
      logic [9:0] x;
      logic [8:0] y;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   err_cnt = 0;
   int   chk_cnt = 0;
   int   pulse_cnt = 0;
   int   pulse_cyc_q[$];
   exp_t sb_q[$];
   int   mx = 0;
   int   my = 0;
   int   wr_cyc = 0;

   bmp_cmd_queue_if #(.XW(10), .YW(9), .IDXW(6)) bus ();

   bmp_cmd_queue #(
      .BASE_ADDR (16'hC008), .DEPTH (DEPTH), .XW (10), .YW (9), .IDXW (6),
      .XSTEP (8), .YSTEP (8), .XMAX (640)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      chk_cnt++;
      if (obs !== exp_v) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
      bus.bmp_sel = 1'b1;
      bus.addr    = a;
      bus.databus = d;
      @(posedge clk);
      #1;
      wr_cyc      = cyc;
      bus.bmp_sel = 1'b0;
   endtask

   task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
      bus.bmp_rd = 1'b1;
      bus.addr   = a;
      @(posedge clk);
      #1;
      bus.bmp_rd = 1'b0;
      d = bus.rdata;
      $display("read  addr=%h data=%h", a, d);
   endtask

   task automatic set_xy(input int x, input int y);
      bus_wr(A_X, 16'(x));
      bus_wr(A_Y, 16'(y));
      mx = x;
      my = y;
   endtask

   // accepted: the FIFO takes it; expect_it: the placer should later see it
   task automatic push_cmd(input logic [15:0] cmd, input bit accepted, input bit expect_it);
      exp_t e;
      e.img = cmd[0];
      e.idx = cmd[6:1];
      e.x   = 10'(mx);
      e.y   = 9'(my);
      if (expect_it) sb_q.push_back(e);
      bus_wr(A_CMD, cmd);
`ifdef BMP_AUTOINC_EN
      if (accepted) begin
         if (mx + 8 >= 640) begin
            mx = 0;
            my = (my + 8) % 512;
         end else begin
            mx = mx + 8;
         end
      end
`else
      if (accepted) mx = mx;
`endif
   endtask

   // Pulse monitor / scoreboard consumer
   always @(negedge clk) begin
      if (rst_n && (bus.add_img || bus.add_fnt)) begin
         pulse_cnt++;
         pulse_cyc_q.push_back(cyc);
         $display("pulse cyc=%0d img=%b fnt=%b idx=%0d x=%0d y=%0d",
                  cyc, bus.add_img, bus.add_fnt, bus.image_indx, bus.xloc, bus.yloc);
         check_val("add_exclusive", {31'b0, bus.add_img & bus.add_fnt}, 32'd0);
         if (sb_q.size() == 0) begin
            check_val("sb_unexpected_pulse", sb_q.size(), 32'd1);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_val("pulse_kind", {31'b0, bus.add_img}, {31'b0, e.img});
            check_val("pulse_idx",  {26'b0, bus.image_indx}, {26'b0, e.idx});
            check_val("pulse_x",    {22'b0, bus.xloc}, {22'b0, e.x});
            check_val("pulse_y",    {23'b0, bus.yloc}, {23'b0, e.y});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [15:0] rd;
      int p0;
      bus.bmp_sel      = 1'b0;
      bus.bmp_rd       = 1'b0;
      bus.addr         = 16'h0000;
      bus.databus      = 16'h0000;
      bus.placer_ready = 1'b0;
      wait_cyc(3);
      rst_n = 1'b1;

      // Reset state
      check_val("rst_add_img", {31'b0, bus.add_img}, 32'd0);
      check_val("rst_add_fnt", {31'b0, bus.add_fnt}, 32'd0);
      check_val("rst_xloc", {22'b0, bus.xloc}, 32'd0);
      check_val("rst_rdata", {16'b0, bus.rdata}, 32'd0);
      bus_rd(A_CTRL, rd);
      check_val("rst_status", {16'b0, rd}, 32'h0020);

      // Single image command, ready high: pulse two edges after CMD write
      bus.placer_ready = 1'b1;
      set_xy(100, 50);
      pulse_cyc_q.delete();
      p0 = pulse_cnt;
      push_cmd(16'h000B, 1, 1);
      wait_cyc(8);
      check_val("t1_pulses", pulse_cnt - p0, 32'd1);
      if (pulse_cyc_q.size() > 0)
         check_val("t1_latency", pulse_cyc_q[0] - wr_cyc, 32'd2);
      else
         check_val("t1_latency_seen", pulse_cyc_q.size(), 32'd1);
      check_val("t1_xloc_hold", {22'b0, bus.xloc}, 32'd100);

      // Font command stalled by ready low, then released
      bus.placer_ready = 1'b0;
      p0 = pulse_cnt;
      push_cmd(16'h0004, 1, 1);
      wait_cyc(20);
      check_val("t2_stall_pulses", pulse_cnt - p0, 32'd0);
      bus_rd(A_CTRL, rd);
      check_val("t2_status", {16'b0, rd}, 32'h0001);
      bus.placer_ready = 1'b1;
      wait_cyc(8);
      check_val("t2_pulses", pulse_cnt - p0, 32'd1);

      // Overflow: DEPTH+1 pushes with ready low
      bus.placer_ready = 1'b0;
      set_xy(16, 20);
      for (int i = 0; i < DEPTH + 1; i++)
         push_cmd(16'((i + 1) << 1 | (i & 1)), i < DEPTH, i < DEPTH);
      bus_rd(A_CTRL, rd);
      check_val("t3_status_full_ovf", {16'b0, rd}, 32'h00C8);
      bus_wr(A_CTRL, 16'h0001);
      bus_rd(A_CTRL, rd);
      check_val("t3_status_ovf_clr", {16'b0, rd}, 32'h0048);
      pulse_cyc_q.delete();
      p0 = pulse_cnt;
      bus.placer_ready = 1'b1;
      wait_cyc(3 * DEPTH + 10);
      check_val("t3_pulses", pulse_cnt - p0, DEPTH);
      for (int i = 1; i < pulse_cyc_q.size(); i++)
         check_val("t3_spacing", pulse_cyc_q[i] - pulse_cyc_q[i-1], 32'd3);

      // Flush discards queued commands; out-of-window writes ignored
      bus.placer_ready = 1'b0;
      for (int i = 0; i < 3; i++) push_cmd(16'h0011, 1, 0);
      bus_wr(A_CTRL, 16'h0002);
      bus_wr(16'hC00C, 16'h0003);
      bus_wr(16'hC007, 16'h0003);
      bus_rd(A_CTRL, rd);
      check_val("t4_status_empty", {16'b0, rd}, 32'h0020);
      p0 = pulse_cnt;
      bus.placer_ready = 1'b1;
      wait_cyc(12);
      check_val("t4_no_pulses", pulse_cnt - p0, 32'd0);

      // Cursor near the X wrap limit
      bus.placer_ready = 1'b0;
      set_xy(632, 0);
      push_cmd(16'h0021, 1, 1);
      push_cmd(16'h0023, 1, 1);
      p0 = pulse_cnt;
      bus.placer_ready = 1'b1;
      wait_cyc(12);
      check_val("t5_pulses", pulse_cnt - p0, 32'd2);

      // Reset while a command is in ISSUE with 4 more queued
      bus.placer_ready = 1'b0;
      set_xy(7, 3);
      for (int i = 0; i < 5; i++) push_cmd(16'h0009, 1, 0);
      bus.placer_ready = 1'b1;
      wait_cyc(1);
      check_val("t6_head_x", {22'b0, bus.xloc}, 32'd7);
      rst_n = 1'b0;
      wait_cyc(1);
      check_val("t6_rst_add_img", {31'b0, bus.add_img}, 32'd0);
      check_val("t6_rst_add_fnt", {31'b0, bus.add_fnt}, 32'd0);
      check_val("t6_rst_xloc", {22'b0, bus.xloc}, 32'd0);
      check_val("t6_rst_yloc", {23'b0, bus.yloc}, 32'd0);
      check_val("t6_rst_idx", {26'b0, bus.image_indx}, 32'd0);
      check_val("t6_rst_rdata", {16'b0, bus.rdata}, 32'd0);
      rst_n = 1'b1;
      mx = 0;
      my = 0;
      p0 = pulse_cnt;
      bus_rd(A_CTRL, rd);
      check_val("t6_status_after_rst", {16'b0, rd}, 32'h0020);
      wait_cyc(12);
      check_val("t6_no_pulses", pulse_cnt - p0, 32'd0);

      check_val("sb_leftover", sb_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/bmp_cmd_queue.md
# bmp_cmd_queue

Parametrised memory-mapped command front-end for the BMP/font placement engine. It sits between the CPU bus decode (`bmp_sel`) and the placer. Draw commands are captured into a DEPTH-entry FIFO so the CPU can issue bursts of sprite and glyph placements without polling, and commands are issued to the placer under a ready handshake. It also adds a readable status register, a sticky overflow flag, flush, and an optional text-cursor auto-advance mode.

## Interface
- `BASE_ADDR`, 16'hC008, base of 4-word register window
- `DEPTH`, 8, FIFO entries (power of 2, ≥2)
- `XW`, 10, X coordinate width
- `YW`, 9, Y coordinate width
- `IDXW`, 6, image/font index width
- `XSTEP`, 8, auto-advance X increment
- `YSTEP`, 8, auto-advance Y increment (line height)
- `XMAX`, 640, X wrap limit
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; synchronous, active-low
- `bmp_sel`  in  1  bus write strobe for this block
- `bmp_rd`  in  1  bus read strobe for this block
- `addr`  in  16  bus address
- `databus`  in  16  bus write data
- `rdata`  out  16  read data, registered
- `placer_ready`  in  1  placer can accept a command
- `add_img`  out  1  one-cycle image-place pulse
- `add_fnt`  out  1  one-cycle glyph-place pulse
- `image_indx`  out  IDXW  index for the issued command
- `xloc`  out  XW  X of the issued command
- `yloc`  out  YW  Y of the issued command

## Operation
- Register map (word offsets from BASE_ADDR):
  - +0 XLOC: write only, `databus[XW-1:0]`.
  - +1 YLOC: write only, `databus[YW-1:0]`.
  - +2 CMD: a write pushes {XLOC, YLOC, `databus[IDXW:1]`, `databus[0]`} into the FIFO. Bit 0 = 1 means image; bit 0 = 0 means font.
  - +3 CTRL/STATUS:
    - Write: bit 0 = 1 clears overflow; bit 1 = 1 flushes the FIFO.
    - Read: {8'b0, overflow, full, empty, count[4:0]}, with count zero-extended or truncated to 5 bits.
- Any access outside the window is ignored.
- FIFO behaviour:
  - A push while full is dropped and sets sticky `overflow`.
  - A push while full in the same cycle as a pop is accepted and does not overflow.
- Issue FSM states:
  - IDLE: when !empty & `placer_ready`, go to ISSUE and pop the head into the output registers.
  - ISSUE: drive `add_img` or `add_fnt` high for one cycle, then go to HOLD.
  - HOLD: one cycle with `placer_ready` ignored, giving the placer time to drop ready, then go to IDLE.
- Outputs:
  - `add_img`/`add_fnt` are never high together and are high only in ISSUE.
  - `xloc`/`yloc`/`image_indx` hold the last issued values until the next issue.
- Flush:
  - Empties the FIFO at the next edge.
  - A command already in ISSUE completes.
  - A CMD push in the same cycle as a flush is discarded.
  - A CTRL write with both bit 0 and bit 1 set performs both actions.
- Reset: all outputs 0, FIFO empty, overflow 0, XLOC/YLOC 0, FSM in IDLE, `rdata` 0.

## Timing
- Push: the CMD write at edge k is visible in status from cycle k+1.
- Issue latency, empty FIFO with ready high: the add pulse is high for exactly the cycle following edge k+2.
- Back-to-back issue rate is at most 1 command per 3 cycles.
- `rdata` is valid the cycle after the `bmp_rd` edge and holds otherwise.
- Status read reflects state before any same-cycle push or pop.
- `placer_ready` low in IDLE stalls indefinitely with no loss; the FIFO keeps accepting commands.

## Configuration
- `BMP_AUTOINC_EN` defined:
  - After each accepted CMD push, XLOC += XSTEP.
  - If the new XLOC ≥ XMAX, XLOC = 0 and YLOC += YSTEP, with YLOC wrapping modulo 2^YW.
  - A same-cycle XLOC/YLOC write is impossible because only one address is accessed per cycle.
  - A dropped push does not advance.
- `BMP_AUTOINC_EN` undefined: XLOC/YLOC change only on explicit writes.

## Structure
- Shared package `bmp_pkg`:
  - Register offset constants (OFS_X, OFS_Y, OFS_CMD, OFS_CTRL).
  - Status bit positions.
  - FSM state encoding {IDLE, ISSUE, HOLD}.
- One sub-module: `bmp_cmd_fifo`, a synchronous FIFO parametrised on width and DEPTH, with push/pop/flush/count/full/empty.

## Test plan
- Reset, then write X=100, Y=50, CMD=16'h000B, with ready high:
  - `add_img` pulses once, 2 cycles after the write.
  - `xloc`=100, `yloc`=50, `image_indx`=5.
- Push CMD=16'h0004 with ready low for 20 cycles, then raise ready:
  - status reads count=1.
  - `add_fnt` pulses once with `image_indx`=2.
- Ready low, push DEPTH+1 commands:
  - status reads full=1, overflow=1, count=DEPTH.
  - CTRL write bit 0 clears overflow.
  - Raising ready issues exactly DEPTH pulses, spaced 3 cycles apart.
- Ready low, push 3 commands, then CTRL write bit 1:
  - status reads empty=1.
  - Raising ready produces no pulses.
- With `BMP_AUTOINC_EN`, X=632, Y=0, two CMD pushes:
  - issued X/Y are (632,0) then (0,8).
- Assert `rst_n` low while in ISSUE with 4 entries queued:
  - the next cycle shows all outputs 0 and count=0.
  - no pulse occurs after release.
